// File: rtl/wisc_pipe_pkg.sv
// ---------------------------------------------------------------------------
// wisc_pipe_pkg
// Shared definitions for the WISC-SP13 inter-stage pipeline registers.
//   NOP_INSTR_16 : instruction word a stage presents when it holds nothing.
//   SQ_CNT_W     : width of the post-flush squash counter.
//   pipe_entry_t : one pipeline entry at the default field widths.
// ---------------------------------------------------------------------------
package wisc_pipe_pkg;

  localparam logic [15:0] NOP_INSTR_16 = 16'h0800;
  localparam int          SQ_CNT_W     = 4;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [1:0]  side;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg
// Enable/clear register for one pipeline entry {instr, pc, side}.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-low reset, loads RST_VAL
//   en   in   load d on the next edge
//   clr  in   load RST_VAL on the next edge (wins over en)
//   d    in   W-bit entry to load
//   q    out  W-bit stored entry
// ---------------------------------------------------------------------------
module pipe_entry_reg #(
  parameter int           W       = 34,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = RST_VAL;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Inter-stage pipeline register with valid/ready handshake, flush and a
// programmable post-flush squash window.
// Optional build macro: PIPE_STAGE_SKID_EN adds a one-entry skid register so
// in_ready comes from a flop instead of out_ready.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   flush      in   kill stage contents, (re)start the squash window
//   in_valid   in   upstream entry valid
//   in_ready   out  stage accepts an entry this cycle
//   in_instr   in   incoming instruction  (INSTR_W)
//   in_pc      in   incoming PC           (PC_W)
//   in_side    in   incoming sideband     (SIDE_W)
//   out_valid  out  output register holds a valid entry
//   out_ready  in   downstream consumes the entry this cycle
//   out_instr  out  registered instruction, NOP_INSTR when not valid
//   out_pc     out  registered PC
//   out_side   out  registered sideband
//   squashing  out  squash counter non-zero
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import wisc_pipe_pkg::*;
#(
  parameter int                 INSTR_W   = 16,
  parameter int                 PC_W      = 16,
  parameter int                 SIDE_W    = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_16),
  parameter int                 SQUASH_N  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [SIDE_W-1:0]  out_side,
  output logic               squashing
);

  localparam int               ENT_W   = INSTR_W + PC_W + SIDE_W;
  localparam logic [ENT_W-1:0] ENT_RST = {NOP_INSTR, {PC_W{1'b0}}, {SIDE_W{1'b0}}};

  logic [ENT_W-1:0]    in_ent;
  logic [ENT_W-1:0]    ent_p1_d;
  logic [ENT_W-1:0]    ent_p1_q;
  logic                ent_p1_en;
  logic                vld_p1_d;
  logic                vld_p1_q;
  logic [SQ_CNT_W-1:0] sq_cnt_d;
  logic [SQ_CNT_W-1:0] sq_cnt_q;
  logic                squashing_d;
  logic                squashing_q;
  logic                accept;
  logic                drain;
  logic                take;
  logic                drop;

  assign in_ent = {in_instr, in_pc, in_side};
  assign accept = in_valid && in_ready;
  assign drain  = vld_p1_q && out_ready;
  // Inputs presented in the flush cycle vanish without touching the counter.
  assign take   = accept && !flush && (sq_cnt_q == '0);
  assign drop   = accept && !flush && (sq_cnt_q != '0);

  always_comb begin
    sq_cnt_d = sq_cnt_q;
    if (flush) begin
      sq_cnt_d = SQ_CNT_W'(SQUASH_N);
    end else if (drop) begin
      sq_cnt_d = sq_cnt_q - 1'b1;
    end
    squashing_d = (sq_cnt_d != '0);
  end

`ifdef PIPE_STAGE_SKID_EN
  logic [ENT_W-1:0] skid_ent_q;
  logic             skid_en;
  logic             skid_vld_d;
  logic             skid_vld_q;
  logic             out_free;

  // Only flush reaches in_ready combinationally; out_ready never does.
  assign in_ready = !skid_vld_q || flush;
  assign out_free = !vld_p1_q || out_ready;

  always_comb begin
    ent_p1_en  = 1'b0;
    ent_p1_d   = in_ent;
    skid_en    = 1'b0;
    skid_vld_d = skid_vld_q;
    vld_p1_d   = vld_p1_q;
    if (flush) begin
      vld_p1_d   = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // in_ready is low here, so the only movement is skid -> output.
      if (drain) begin
        ent_p1_en  = 1'b1;
        ent_p1_d   = skid_ent_q;
        vld_p1_d   = 1'b1;
        skid_vld_d = 1'b0;
      end
    end else if (take) begin
      if (out_free) begin
        ent_p1_en = 1'b1;
        vld_p1_d  = 1'b1;
      end else begin
        skid_en    = 1'b1;
        skid_vld_d = 1'b1;
      end
    end else if (drain) begin
      vld_p1_d = 1'b0;
    end
  end

  pipe_entry_reg #(
    .W       (ENT_W),
    .RST_VAL (ENT_RST)
  ) u_skid_reg (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .clr (flush),
    .d   (in_ent),
    .q   (skid_ent_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_vld_q <= 1'b0;
    end else begin
      skid_vld_q <= skid_vld_d;
    end
  end
`else
  assign in_ready = !vld_p1_q || out_ready || flush;

  always_comb begin
    ent_p1_d  = in_ent;
    ent_p1_en = take;
    vld_p1_d  = vld_p1_q;
    if (flush) begin
      vld_p1_d = 1'b0;
    end else if (take) begin
      vld_p1_d = 1'b1;
    end else if (drain) begin
      vld_p1_d = 1'b0;
    end
  end
`endif

  // ---- stage p0 -> p1 boundary ----
  pipe_entry_reg #(
    .W       (ENT_W),
    .RST_VAL (ENT_RST)
  ) u_out_reg (
    .clk (clk),
    .rst (rst),
    .en  (ent_p1_en),
    .clr (flush),
    .d   (ent_p1_d),
    .q   (ent_p1_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q    <= 1'b0;
      sq_cnt_q    <= '0;
      squashing_q <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      sq_cnt_q    <= sq_cnt_d;
      squashing_q <= squashing_d;
    end
  end

  assign out_valid = vld_p1_q;
  assign out_instr = vld_p1_q ? ent_p1_q[ENT_W-1 -: INSTR_W] : NOP_INSTR;
  assign out_pc    = ent_p1_q[SIDE_W +: PC_W];
  assign out_side  = ent_p1_q[SIDE_W-1:0];
  assign squashing = squashing_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = 16'h0;
  logic [15:0] in_pc = 16'h0;
  logic [1:0]  in_side = 2'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_1, out_valid_1, squashing_1;
  logic [15:0] out_instr_1, out_pc_1;
  logic [1:0]  out_side_1;
  logic        in_ready_3, out_valid_3, squashing_3;
  logic [15:0] out_instr_3, out_pc_3;
  logic [1:0]  out_side_3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SQUASH_N(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_instr(in_instr), .in_pc(in_pc), .in_side(in_side), .out_valid(out_valid_1),
    .out_ready(out_ready), .out_instr(out_instr_1), .out_pc(out_pc_1),
    .out_side(out_side_1), .squashing(squashing_1)
  );

  pipe_stage_reg #(.SQUASH_N(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_3),
    .in_instr(in_instr), .in_pc(in_pc), .in_side(in_side), .out_valid(out_valid_3),
    .out_ready(out_ready), .out_instr(out_instr_3), .out_pc(out_pc_3),
    .out_side(out_side_3), .squashing(squashing_3)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [15:0] pc;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_vld;
    logic [15:0] exp_pc;
    logic        chk_pc;
    logic        exp_sq;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Instruction word carried with each PC, so order and content are both visible.
  function automatic logic [15:0] instr_of(input logic [15:0] pc);
    return 16'h1000 | pc;
  endfunction

  task automatic drive(input logic fl, input logic iv, input logic [15:0] pc, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    in_side   = pc[2:1];
    out_ready = ordy;
  endtask

  task automatic step(input logic fl, input logic iv, input logic [15:0] pc, input logic ordy);
    drive(fl, iv, pc, ordy);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    // fl iv pc ordy | rdy vld pc chkpc sq   (expected for dut1, SQUASH_N=1)
    // streaming, no bubbles
    vecs.push_back('{0, 1, 16'h0000, 1, 1, 1, 16'h0000, 1, 0});
    vecs.push_back('{0, 1, 16'h0002, 1, 1, 1, 16'h0002, 1, 0});
    vecs.push_back('{0, 1, 16'h0004, 1, 1, 1, 16'h0004, 1, 0});
    vecs.push_back('{0, 1, 16'h0006, 1, 1, 1, 16'h0006, 1, 0});
    vecs.push_back('{0, 1, 16'h0008, 1, 1, 1, 16'h0008, 1, 0});
    vecs.push_back('{0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0});
    // stall with pc=0x0010 held for three cycles
    vecs.push_back('{0, 1, 16'h0010, 0, 1, 1, 16'h0010, 1, 0});
`ifdef PIPE_STAGE_SKID_EN
    vecs.push_back('{0, 1, 16'h0012, 0, 1, 1, 16'h0010, 1, 0});
    vecs.push_back('{0, 1, 16'h0014, 0, 0, 1, 16'h0010, 1, 0});
    vecs.push_back('{0, 1, 16'h0014, 0, 0, 1, 16'h0010, 1, 0});
    vecs.push_back('{0, 0, 16'h0000, 1, 0, 1, 16'h0012, 1, 0});
`else
    vecs.push_back('{0, 1, 16'h0012, 0, 0, 1, 16'h0010, 1, 0});
    vecs.push_back('{0, 1, 16'h0012, 0, 0, 1, 16'h0010, 1, 0});
    vecs.push_back('{0, 1, 16'h0012, 0, 0, 1, 16'h0010, 1, 0});
    vecs.push_back('{0, 1, 16'h0012, 1, 1, 1, 16'h0012, 1, 0});
`endif
    // flush with valid input and out_ready=1 while out_valid=1
    vecs.push_back('{1, 1, 16'h0014, 1, 1, 0, 16'h0000, 1, 1});
    vecs.push_back('{0, 1, 16'h0020, 1, 1, 0, 16'h0000, 1, 0});
    vecs.push_back('{0, 1, 16'h0022, 1, 1, 1, 16'h0022, 1, 0});
    // flush with no input; idle cycle must not consume the window
    vecs.push_back('{1, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 1});
    vecs.push_back('{0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 1});
    vecs.push_back('{0, 1, 16'h0030, 1, 1, 0, 16'h0000, 1, 0});
    vecs.push_back('{0, 1, 16'h0032, 0, 1, 1, 16'h0032, 1, 0});
    // flush while stalled with a valid entry
    vecs.push_back('{1, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 1});

    // reset state, checked before any clock edge
    #1;
    chk("rst_out_valid", out_valid_1, 0);
    chk("rst_out_instr", out_instr_1, 16'h0800);
    chk("rst_out_pc", out_pc_1, 0);
    chk("rst_out_side", out_side_1, 0);
    chk("rst_squashing", squashing_1, 0);
    chk("rst_in_ready", in_ready_1, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready_1, vecs[i].exp_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), out_valid_1, vecs[i].exp_vld);
      chk($sformatf("v%0d_out_instr", i), out_instr_1,
          vecs[i].exp_vld ? instr_of(vecs[i].exp_pc) : 16'h0800);
      if (vecs[i].chk_pc) begin
        chk($sformatf("v%0d_out_pc", i), out_pc_1, vecs[i].exp_pc);
        chk($sformatf("v%0d_out_side", i), out_side_1, vecs[i].exp_pc[2:1]);
      end
      chk($sformatf("v%0d_squashing", i), squashing_1, vecs[i].exp_sq);
    end

    // SQUASH_N=3: second flush at sq_cnt=1 reloads the window to 3
    step(1, 0, 16'h0000, 1);
    chk("sq3_flush_a", squashing_3, 1);
    step(0, 1, 16'h0040, 1);
    chk("sq3_drop40", squashing_3, 1);
    step(0, 1, 16'h0042, 1);
    chk("sq3_drop42", squashing_3, 1);
    chk("sq3_drop42_vld", out_valid_3, 0);
    step(1, 1, 16'h0044, 1);
    chk("sq3_flush_b", squashing_3, 1);
    step(0, 1, 16'h0050, 1);
    chk("sq3_drop50", squashing_3, 1);
    chk("sq3_drop50_vld", out_valid_3, 0);
    step(0, 1, 16'h0052, 1);
    chk("sq3_drop52", squashing_3, 1);
    chk("sq3_drop52_vld", out_valid_3, 0);
    step(0, 1, 16'h0054, 1);
    chk("sq3_drop54", squashing_3, 0);
    chk("sq3_drop54_vld", out_valid_3, 0);
    step(0, 1, 16'h0056, 1);
    chk("sq3_pass56_vld", out_valid_3, 1);
    chk("sq3_pass56_pc", out_pc_3, 16'h0056);
    chk("sq3_pass56_instr", out_instr_3, instr_of(16'h0056));

    // asynchronous reset mid-stream with a valid entry held
    step(0, 1, 16'h0060, 0);
    chk("pre_rst_vld", out_valid_1, 1);
    drive(0, 0, 16'h0000, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_vld", out_valid_1, 0);
    chk("async_rst_instr", out_instr_1, 16'h0800);
    chk("async_rst_pc", out_pc_1, 0);
    chk("async_rst_vld3", out_valid_3, 0);
    chk("async_rst_sq3", squashing_3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
